// File: rtl/fifo_enq_arbiter_pkg.sv
// Shared types for the FIFO enqueue arbiter: FSM state encoding and index-width helpers.
// Package name is fifo_types so other schedulers can reuse it alongside rr_pick.
package fifo_types;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_cnt_w(input int burst);
    return $clog2(burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_if.sv
// Handshake bundle between N producers, the enqueue arbiter and one FIFO enqueue port.
// FIFO_ARB_TAG_EN widens fifo_data_o by idx_w bits to carry the grant index.
interface fifo_enq_arbiter_if
  import fifo_types::*;
#(
  parameter int num_req_p = 4,
  parameter int width_p   = 8
);

  localparam int idx_w = calc_idx_w(num_req_p);
`ifdef FIFO_ARB_TAG_EN
  localparam int out_w = width_p + idx_w;
`else
  localparam int out_w = width_p;
`endif

  logic [num_req_p-1:0] req_valid_i;
  logic [width_p-1:0]   req_data_i [num_req_p];
  logic [num_req_p-1:0] req_ready_o;
  logic                 fifo_valid_o;
  logic [out_w-1:0]     fifo_data_o;
  logic                 fifo_ready_i;
  logic [idx_w-1:0]     grant_id_o;
  logic                 busy_o;

  modport master (
    input  req_valid_i,
    input  req_data_i,
    input  fifo_ready_i,
    output req_ready_o,
    output fifo_valid_o,
    output fifo_data_o,
    output grant_id_o,
    output busy_o
  );

  modport slave (
    output req_valid_i,
    output req_data_i,
    output fifo_ready_i,
    input  req_ready_o,
    input  fifo_valid_o,
    input  fifo_data_o,
    input  grant_id_o,
    input  busy_o
  );

endinterface

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. Returns the first set request
// at or after ptr, wrapping past num_req_p-1 to 0, plus a flag telling whether any was set.
module rr_pick
  import fifo_types::*;
#(
  parameter int  num_req_p = 4,
  localparam int idx_w     = calc_idx_w(num_req_p)
) (
  input  logic [num_req_p-1:0] req,
  input  logic [idx_w-1:0]     ptr,
  output logic [idx_w-1:0]     idx,
  output logic                 any
);

  localparam int sum_w = idx_w + 1;

  // cand[k] is the index examined k positions after ptr. The wrap compares against
  // num_req_p-1 explicitly so non-power-of-two requester counts rotate correctly.
  logic [idx_w-1:0] cand [num_req_p];

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_cand
      logic [sum_w-1:0] sum;
      assign sum = {1'b0, ptr} + sum_w'(gi);
      assign cand[gi] = (sum > sum_w'(num_req_p - 1)) ? idx_w'(sum - sum_w'(num_req_p))
                                                       : sum[idx_w-1:0];
    end
  endgenerate

  // Scan from the farthest offset back to ptr so the nearest set request wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin burst arbiter sharing one FIFO enqueue port among num_req_p producers.
// Optional macro FIFO_ARB_TAG_EN prefixes each enqueued word with the granted index.
module fifo_enq_arbiter
  import fifo_types::*;
#(
  parameter int num_req_p = 4,
  parameter int width_p   = 8,
  parameter int burst_p   = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  fifo_enq_arbiter_if.master  bus
);

  localparam int idx_w = calc_idx_w(num_req_p);
  localparam int cnt_w = calc_cnt_w(burst_p);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(burst_p - 1);
  localparam logic [idx_w-1:0] last_idx  = idx_w'(num_req_p - 1);

  arb_state_e         state;
  logic [idx_w-1:0]   grant_id;
  logic [idx_w-1:0]   rr_ptr;
  logic [cnt_w-1:0]   beat_cnt;

  logic [idx_w-1:0]   pick_idx;
  logic               pick_any;
  logic [idx_w-1:0]   next_ptr;
  logic               gnt_active;
  logic               gnt_valid;
  logic [width_p-1:0] gnt_data;
  logic               beat;
  logic               burst_done;

  rr_pick #(
    .num_req_p (num_req_p)
  ) u_pick (
    .req (bus.req_valid_i),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the granted requester's valid/data reach the outputs; reset forces them quiet.
  assign gnt_active = (state == GRANT) && !reset_i;
  assign gnt_valid  = bus.req_valid_i[grant_id];
  assign gnt_data   = bus.req_data_i[grant_id];
  assign beat       = gnt_valid && bus.fifo_ready_i;
  assign burst_done = beat && (beat_cnt == last_beat);
  assign next_ptr   = (grant_id == last_idx) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A dropped valid ends the burst; a FIFO stall simply holds beat_cnt.
          if (!gnt_valid || burst_done) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_ready
      assign bus.req_ready_o[gi] = gnt_active && (grant_id == idx_w'(gi)) && bus.fifo_ready_i;
    end
  endgenerate

  assign bus.fifo_valid_o = gnt_active && gnt_valid;
`ifdef FIFO_ARB_TAG_EN
  assign bus.fifo_data_o  = gnt_active ? {grant_id, gnt_data} : '0;
`else
  assign bus.fifo_data_o  = gnt_active ? gnt_data : '0;
`endif
  assign bus.grant_id_o   = reset_i ? '0 : grant_id;
  assign bus.busy_o       = gnt_active;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter: 4 requesters, 8-bit data, 4-beat bursts.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_fifo_enq_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;
`ifdef FIFO_ARB_TAG_EN
  localparam bit tag_en = 1'b1;
`else
  localparam bit tag_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_enq_arbiter_if #(.num_req_p(N), .width_p(W)) bus ();

  fifo_enq_arbiter #(
    .num_req_p (N),
    .width_p   (W),
    .burst_p   (B)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.master)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int order [5] = '{0, 1, 2, 3, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [1:0] gid, input logic [7:0] d);
    return tag_en ? {22'd0, gid, d} : {24'd0, d};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " busy"},  32'(bus.busy_o), 32'd0);
    check({tag, " valid"}, 32'(bus.fifo_valid_o), 32'd0);
    check({tag, " ready"}, 32'(bus.req_ready_o), 32'd0);
    $display("idle  %s", tag);
  endtask

  task automatic expect_beat(input string tag, input logic [1:0] gid, input logic [7:0] d,
                             input logic rdy);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << gid;
    check({tag, " busy"},  32'(bus.busy_o), 32'd1);
    check({tag, " valid"}, 32'(bus.fifo_valid_o), 32'd1);
    check({tag, " grant"}, 32'(bus.grant_id_o), 32'(gid));
    check({tag, " data"},  32'(bus.fifo_data_o), word(gid, d));
    check({tag, " ready"}, 32'(bus.req_ready_o), rdy ? 32'(one_hot) : 32'd0);
    $display("beat  %s gid=%0d data=0x%0h ready=%0b", tag, gid, d, rdy);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid_i  = '0;
    bus.fifo_ready_i = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data_i[i] = '0;

    // Reset state
    next_cycle();
    next_cycle();
    settle();
    expect_idle("reset");
    check("reset grant", 32'(bus.grant_id_o), 32'd0);
    check("reset data", 32'(bus.fifo_data_o), 32'd0);
    check("reset rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // Single requester 2, six words: a 4-beat burst, one IDLE cycle, then 2 beats
    next_cycle();
    rst              = 1'b0;
    bus.req_valid_i  = 4'b0100;
    bus.req_data_i[2] = 8'h10;
    bus.fifo_ready_i = 1'b1;
    settle();
    expect_idle("single.arb");
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.req_data_i[2] = 8'(8'h10 + k);
      settle();
      expect_beat("single.b1", 2'd2, 8'(8'h10 + k), 1'b1);
    end
    next_cycle();
    bus.req_data_i[2] = 8'h14;
    settle();
    expect_idle("single.gap");
    check("single rr_ptr1", 32'(dut.rr_ptr), 32'd3);
    for (int k = 4; k < 6; k++) begin
      next_cycle();
      bus.req_data_i[2] = 8'(8'h10 + k);
      settle();
      expect_beat("single.b2", 2'd2, 8'(8'h10 + k), 1'b1);
    end
    next_cycle();
    bus.req_valid_i = '0;
    settle();
    check("single.drop busy", 32'(bus.busy_o), 32'd1);
    check("single.drop valid", 32'(bus.fifo_valid_o), 32'd0);
    next_cycle();
    settle();
    expect_idle("single.end");
    check("single rr_ptr2", 32'(dut.rr_ptr), 32'd3);

    // All four continuously valid: grants 0,1,2,3,0, 4 beats each, 1 IDLE between
    next_cycle();
    rst = 1'b1;
    settle();
    next_cycle();
    rst             = 1'b0;
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_data_i[i] = 8'(8'hA0 + i);
    settle();
    for (int j = 0; j < 5; j++) begin
      expect_idle($sformatf("rr.gap%0d", j));
      for (int k = 0; k < 4; k++) begin
        next_cycle();
        settle();
        expect_beat($sformatf("rr.g%0d.b%0d", j, k), 2'(order[j]), 8'(8'hA0 + order[j]), 1'b1);
      end
      next_cycle();
      settle();
    end
    check("rr rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // Backpressure on requester 1: 5 stall cycles after two beats
    bus.req_valid_i   = 4'b1010;
    bus.req_data_i[1] = 8'h30;
    bus.req_data_i[3] = 8'h77;
    next_cycle();
    settle();
    expect_beat("bp.b0", 2'd1, 8'h30, 1'b1);
    next_cycle();
    bus.req_data_i[1] = 8'h31;
    settle();
    expect_beat("bp.b1", 2'd1, 8'h31, 1'b1);
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      bus.fifo_ready_i  = 1'b0;
      bus.req_data_i[1] = 8'h32;
      settle();
      expect_beat($sformatf("bp.stall%0d", s), 2'd1, 8'h32, 1'b0);
      check("bp beat_cnt", 32'(dut.beat_cnt), 32'd2);
    end
    next_cycle();
    bus.fifo_ready_i = 1'b1;
    settle();
    expect_beat("bp.b2", 2'd1, 8'h32, 1'b1);
    next_cycle();
    bus.req_data_i[1] = 8'h33;
    settle();
    expect_beat("bp.b3", 2'd1, 8'h33, 1'b1);
    next_cycle();
    settle();
    expect_idle("bp.end");
    check("bp rr_ptr", 32'(dut.rr_ptr), 32'd2);

    // Early drop by requester 3 after one beat, then wrap-around to requester 0
    bus.req_data_i[3] = 8'h40;
    next_cycle();
    settle();
    expect_beat("drop.b0", 2'd3, 8'h40, 1'b1);
    next_cycle();
    bus.req_valid_i   = 4'b0011;
    bus.req_data_i[0] = 8'h50;
    settle();
    check("drop busy", 32'(bus.busy_o), 32'd1);
    check("drop valid", 32'(bus.fifo_valid_o), 32'd0);
    check("drop ready", 32'(bus.req_ready_o), 32'h8);
    next_cycle();
    settle();
    expect_idle("drop.idle");
    check("drop rr_ptr", 32'(dut.rr_ptr), 32'd0);
    next_cycle();
    settle();
    expect_beat("drop.wrap", 2'd0, 8'h50, 1'b1);

    // Reset after the second beat of requester 0's burst
    next_cycle();
    bus.req_data_i[0] = 8'h51;
    settle();
    expect_beat("rst.b1", 2'd0, 8'h51, 1'b1);
    next_cycle();
    rst = 1'b1;
    settle();
    expect_idle("rst.live");
    check("rst.live data", 32'(bus.fifo_data_o), 32'd0);
    check("rst.live grant", 32'(bus.grant_id_o), 32'd0);
    next_cycle();
    rst               = 1'b0;
    bus.req_valid_i   = 4'b1110;
    bus.req_data_i[1] = 8'h60;
    settle();
    expect_idle("rst.after");
    check("rst.after grant", 32'(bus.grant_id_o), 32'd0);
    check("rst.after data", 32'(bus.fifo_data_o), 32'd0);
    check("rst.after rr_ptr", 32'(dut.rr_ptr), 32'd0);
    check("rst.after beat_cnt", 32'(dut.beat_cnt), 32'd0);
    next_cycle();
    settle();
    expect_beat("rst.next", 2'd1, 8'h60, 1'b1);
    next_cycle();
    bus.req_valid_i = '0;
    settle();
    check("rst.drop valid", 32'(bus.fifo_valid_o), 32'd0);
    next_cycle();
    settle();
    expect_idle("rst.end");
    check("rst.end rr_ptr", 32'(dut.rr_ptr), 32'd2);

    // Requester 2 sends 0xAB; tagged builds see the index in the upper bits
    bus.req_valid_i   = 4'b0100;
    bus.req_data_i[2] = 8'hAB;
    next_cycle();
    settle();
    expect_beat("tag", 2'd2, 8'hAB, 1'b1);
    next_cycle();
    bus.req_valid_i = '0;
    settle();
    next_cycle();
    settle();
    expect_idle("tag.end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Round-robin arbiter that shares the single valid-ready enqueue port of one FIFO buffer among `num_req_p` producers in the HE datapath. Each grant is a burst of up to `burst_p` beats from one requester, so a requester's words stay contiguous in the FIFO. A two-state FSM sequences grants and a rotating priority pointer guarantees fairness. The block sits directly in front of the FIFO's `data_i`/`valid_i`/`ready_o` port.

## Interface
Parameters:
- `num_req_p`, 4: number of requesters, ≥2.
- `width_p`, 8: data word width; matches the FIFO `width_p`.
- `burst_p`, 4: maximum beats per grant, ≥1.

Ports:
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `req_valid_i` input `num_req_p`: per-requester valid.
- `req_data_i` input `num_req_p`×`width_p` (unpacked array): per-requester data.
- `req_ready_o` output `num_req_p`: per-requester ready, one-hot or zero.
- `fifo_valid_o` output 1: drives FIFO `valid_i`.
- `fifo_data_o` output `width_p` (+`idx_w` with tag): drives FIFO `data_i`.
- `fifo_ready_i` input 1: from FIFO `ready_o`.
- `grant_id_o` output `idx_w`: current grant index, where `idx_w` = `$clog2(num_req_p)`.
- `busy_o` output 1: high in state GRANT.

## Operation
- FSM states: IDLE and GRANT. Registers are `state`, `grant_id`, `rr_ptr` (`idx_w`) and `beat_cnt` (`$clog2(burst_p)+1` bits).
- **IDLE**
  - `fifo_valid_o`=0 and `req_ready_o`=0.
  - If any `req_valid_i` is set, pick the first set index searching `rr_ptr`, `rr_ptr`+1, … modulo `num_req_p`, wrapping past `num_req_p`-1 to 0.
  - Load `grant_id`, clear `beat_cnt`, and go to GRANT.
- **GRANT**
  - `fifo_valid_o` = `req_valid_i[grant_id]` and `fifo_data_o` = `req_data_i[grant_id]`.
  - `req_ready_o[grant_id]` = `fifo_ready_i`; all other ready bits are 0.
  - A beat is `fifo_valid_o & fifo_ready_i`; each beat increments `beat_cnt`.
- **Exit to IDLE** occurs on either condition below. On exit, `rr_ptr` ← `grant_id`+1 mod `num_req_p`.
  - The beat completes the `burst_p`-th transfer (`beat_cnt`==`burst_p`-1 and a beat occurs).
  - `req_valid_i[grant_id]` is low in the cycle. A requester's valid dropping ends its burst.
- **FIFO full** (`fifo_ready_i`=0): stay in GRANT with `beat_cnt` held. The stall does not count toward the burst and causes no timeout.
- Non-granted requesters never see ready. Their valid/data must be held per valid-ready rules; the arbiter does not sample them outside IDLE selection.
- Ports with a non-power-of-two `num_req_p`: the wrap uses an explicit compare with `num_req_p`-1, not bit truncation.
- **Reset**
  - Applies from any state, including mid-burst: `state`=IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0.
  - Output values under reset: `fifo_valid_o`=0, `req_ready_o`=0, `fifo_data_o`=0, `grant_id_o`=0, `busy_o`=0.
  - A burst interrupted by reset is abandoned. Beats already accepted by the FIFO remain there.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives `fifo_valid_o` in cycle N+1.
- Minimum gap between bursts: 1 IDLE cycle.
- Throughput: `burst_p`/(`burst_p`+1) when all requesters are continuously valid and the FIFO never fills.
- All outputs are combinational from registered state plus the granted requester's valid/data and `fifo_ready_i`. There is no path from a non-granted input to any output.
- `req_ready_o` depends combinationally on `fifo_ready_i`; the FIFO's `ready_o` is registered-derived, so no loop exists.

## Configuration
- `FIFO_ARB_TAG_EN` defined:
  - `fifo_data_o` is `idx_w`+`width_p` bits wide, laid out as {`grant_id`, `req_data_i[grant_id]`}.
  - The downstream FIFO must be instantiated with `width_p`+`idx_w`.
- `FIFO_ARB_TAG_EN` undefined: `fifo_data_o` is `width_p` bits and carries data only.

## Structure
- Shared package `fifo_types`: the `arb_state_e` enum (IDLE, GRANT) and an `idx_w` helper function.
- Sub-module `rr_pick`: a combinational rotating priority encoder.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: index and `any` flag.
  - Reusable by other schedulers in the design.

## Test plan
- **Single requester:** reset, then `req_valid_i`=4'b0100 with data 0x10..0x15 and `fifo_ready_i`=1.
  - Expect beats 0x10–0x13 with `grant_id_o`=2, then 1 IDLE cycle, then 0x14–0x15.
  - Expect `rr_ptr`=3 after each burst.
- **All four requesters always valid:** expect grant order 0,1,2,3,0, with exactly 4 beats per grant and 1 IDLE cycle between grants.
- **Backpressure:** in GRANT to requester 1, hold `fifo_ready_i`=0 for 5 cycles after beat 2.
  - Expect `beat_cnt` to hold, and data to stay stable with `fifo_valid_o`=1.
  - Expect the burst to end after exactly 4 total beats.
- **Early drop:** requester 3 drops valid after 1 beat.
  - Expect IDLE on the next edge, then a grant to requester 0 if valid (wrap-around).
- **Reset mid-burst:** assert `reset_i` after beat 2.
  - Expect all outputs at reset values on the next cycle and `rr_ptr`=0.
  - Expect the next grant to go to the lowest valid index.
- **`FIFO_ARB_TAG_EN`:** requester 2 sends 0xAB.
  - Expect `fifo_data_o`=0x2AB with `num_req_p`=4 and `width_p`=8.
